abr_prim_ext_reg_arb: RTL and testbench

// - Shares one external-register access port (re/we strobes, wd data, d readback) among NREQ requesters.
// - Sequences each access: round-robin grant, one-cycle strobe, wait for ext_ack_i, one-cycle response.
// - Sits between the register-file requesters (e.g. TL-UL adapter, HW sequencer) and a bank of

---
 rtl/abr_prim_ext_reg_arb.sv | 172 +++++++++++++++++
 tb/tb_abr_prim_ext_reg_arb.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/abr_prim_ext_reg_arb.sv
// abr_prim_ext_reg_arb
//   Round-robin arbiter that shares one external-register access port
//   (re/we strobes, wd, d readback) among NREQ requesters. Each access runs
//   IDLE -> ISSUE -> [WAIT] -> RESP, giving the external subregister a
//   single-cycle strobe and the requester a single-cycle response.
//   Optional feature macro: ABR_EXT_REG_ARB_TIMEOUT_EN. When it is defined,
//   an access without ext_ack_i completes with an error after TIMEOUT_CYC
//   cycles. When it is not defined, WAIT holds indefinitely and rsp_err_o is 0.
module abr_prim_ext_reg_arb #(
    parameter int unsigned NREQ        = 2,
    parameter int unsigned DW          = 32,
    parameter int unsigned AW          = 8,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NREQ-1:0]    req_i,
    input  logic [NREQ-1:0]    req_we_i,
    input  logic [NREQ*AW-1:0] req_addr_i,
    input  logic [NREQ*DW-1:0] req_wdata_i,
    output logic [NREQ-1:0]    gnt_o,
    output logic [NREQ-1:0]    rsp_valid_o,
    output logic [DW-1:0]      rsp_rdata_o,
    output logic               rsp_err_o,
    output logic               ext_re_o,
    output logic               ext_we_o,
    output logic [AW-1:0]      ext_addr_o,
    output logic [DW-1:0]      ext_wd_o,
    input  logic [DW-1:0]      ext_rd_i,
    input  logic               ext_ack_i
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    state_e                  state_q;
    logic [IW-1:0]           ptr_q;     // last winner; search starts after it
    logic [IW-1:0]           cur_q;     // requester owning the access in flight
    logic                    we_q;
    logic                    expired;   // forced completion this cycle

    logic [NREQ-1:0][AW-1:0] addr_v;
    logic [NREQ-1:0][DW-1:0] wdata_v;
    logic [IW-1:0]           cand;
    logic [IW-1:0]           win_idx;
    logic                    win_vld;

    // Packed-array views of the flat request buses (requester i at slot i).
    assign addr_v  = req_addr_i;
    assign wdata_v = req_wdata_i;

    // Round-robin pick: first requester set, searching ptr+1, ptr+2, ... mod NREQ.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int k = 1; k <= int'(NREQ); k++) begin
            cand = IW'((int'(ptr_q) + k) % int'(NREQ));
            if (!win_vld && req_i[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    // Grant is combinational in IDLE. It is forced low while reset is asserted
    // so that every output reads 0 during reset.
    assign gnt_o = (rst_ni && (state_q == IDLE) && win_vld) ? (NREQ'(1) << win_idx) : '0;

    // Access sequencer with registered strobe, address, data and response outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            ptr_q       <= IW'(NREQ - 1);
            cur_q       <= '0;
            we_q        <= 1'b0;
            ext_re_o    <= 1'b0;
            ext_we_o    <= 1'b0;
            ext_addr_o  <= '0;
            ext_wd_o    <= '0;
            rsp_valid_o <= '0;
            rsp_rdata_o <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (win_vld) begin
                        state_q    <= ISSUE;
                        ptr_q      <= win_idx;
                        cur_q      <= win_idx;
                        we_q       <= req_we_i[win_idx];
                        ext_re_o   <= !req_we_i[win_idx];
                        ext_we_o   <= req_we_i[win_idx];
                        ext_addr_o <= addr_v[win_idx];
                        ext_wd_o   <= wdata_v[win_idx];
                    end
                end
                ISSUE, WAIT: begin
                    // The strobe lasts exactly one cycle. The address and data
                    // stay on the port until the access completes.
                    ext_re_o <= 1'b0;
                    ext_we_o <= 1'b0;
                    if (ext_ack_i || expired) begin
                        state_q     <= RESP;
                        rsp_valid_o <= NREQ'(1) << cur_q;
                        rsp_rdata_o <= (ext_ack_i && !we_q) ? ext_rd_i : '0;
                        ext_addr_o  <= '0;
                        ext_wd_o    <= '0;
                    end else begin
                        state_q <= WAIT;
                    end
                end
                RESP: begin
                    state_q     <= IDLE;
                    rsp_valid_o <= '0;
                    rsp_rdata_o <= '0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef ABR_EXT_REG_ARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] cnt_q;
    logic          err_q;
    logic          busy;

    assign busy    = (state_q == ISSUE) || (state_q == WAIT);
    assign expired = busy && (cnt_q == CW'(TIMEOUT_CYC - 1));

    // Outstanding-access cycle counter. It is cleared outside ISSUE and WAIT.
    // The FSM leaves on expiry, so the counter never wraps.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (busy) begin
            cnt_q <= cnt_q + 1'b1;
        end else begin
            cnt_q <= '0;
        end
    end

    // Error flag for a forced completion. An ack on the expiry cycle wins.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else if (busy && expired && !ext_ack_i) begin
            err_q <= 1'b1;
        end else if (state_q == RESP) begin
            err_q <= 1'b0;
        end
    end

    assign rsp_err_o = err_q;
`else
    logic unused_timeout;

    assign unused_timeout = ^TIMEOUT_CYC;
    assign expired        = 1'b0;
    assign rsp_err_o      = 1'b0;
`endif

endmodule

// File: tb/tb_abr_prim_ext_reg_arb.sv
// tb_abr_prim_ext_reg_arb
//   Scoreboard bench: each access is pushed as an expectation when it is
//   requested. Grants, strobes and responses are compared against the head of
//   the queue as the DUT produces them. A small slave model acks after a
//   programmable delay.
`timescale 1ns/1ps
module tb_abr_prim_ext_reg_arb;

    localparam int NREQ = 2;
    localparam int DW   = 32;
    localparam int AW   = 8;
`ifdef ABR_EXT_REG_ARB_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 255;
`endif

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [NREQ-1:0]    req_i = '0;
    logic [NREQ-1:0]    req_we_i = '0;
    logic [NREQ*AW-1:0] req_addr_i = '0;
    logic [NREQ*DW-1:0] req_wdata_i = '0;
    logic [NREQ-1:0]    gnt_o;
    logic [NREQ-1:0]    rsp_valid_o;
    logic [DW-1:0]      rsp_rdata_o;
    logic               rsp_err_o;
    logic               ext_re_o;
    logic               ext_we_o;
    logic [AW-1:0]      ext_addr_o;
    logic [DW-1:0]      ext_wd_o;
    logic [DW-1:0]      ext_rd_i = '0;
    logic               ext_ack_i = 1'b0;

    abr_prim_ext_reg_arb #(
        .NREQ(NREQ), .DW(DW), .AW(AW), .TIMEOUT_CYC(TO)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_i(req_i), .req_we_i(req_we_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .gnt_o(gnt_o), .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .ext_re_o(ext_re_o), .ext_we_o(ext_we_o), .ext_addr_o(ext_addr_o), .ext_wd_o(ext_wd_o),
        .ext_rd_i(ext_rd_i), .ext_ack_i(ext_ack_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NREQ-1:0] gnt;
        logic            we;
        logic [AW-1:0]   addr;
        logic [DW-1:0]   wd;
        logic [DW-1:0]   rdata;
        logic            err;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   want[NREQ]    = '{default: 0};
    int   granted[NREQ] = '{default: 0};
    int   ack_dly = 0;
    bit   ack_en  = 1'b1;
    bit   spur    = 1'b0;
    int   pend    = -1;
    int   cyc     = 0;
    int   t_gnt = 0, t_stb = 0, t_rsp = 0, n_stb = 0, n_rsp = 0;
    bit   inflight = 1'b0;
    bit   prev_stb = 1'b0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic set_req(input int r, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
        req_we_i[r]             = we;
        req_addr_i[r*AW +: AW]  = a;
        req_wdata_i[r*DW +: DW] = wd;
    endtask

    task automatic push(input int r, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd, input logic [DW-1:0] rd, input logic err);
        exp_t e;
        e.gnt    = '0;
        e.gnt[r] = 1'b1;
        e.we     = we;
        e.addr   = a;
        e.wd     = wd;
        e.rdata  = rd;
        e.err    = err;
        exp_q.push_back(e);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk(tag, exp_q.size(), 0);
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #2;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Requesters hold req until granted. The slave acks ack_dly cycles after the strobe.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < NREQ; i++) req_i[i] = (granted[i] < want[i]);
        if (!rst_n) pend = -1;
        else if (ext_re_o | ext_we_o) pend = ack_dly;
        else if (pend > 0) pend = pend - 1;
        ext_ack_i = spur;
        if (pend == 0) begin
            ext_ack_i = ack_en | spur;
            pend      = -1;
        end
    end

    // Monitor: compare DUT activity against the head of the scoreboard.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst_n) begin
            inflight = 1'b0;
            prev_stb = 1'b0;
        end else begin
            if (gnt_o != '0) begin
                t_gnt = cyc;
                chk("gnt_req", gnt_o & ~req_i, 0);
                if (exp_q.size() == 0) chk("gnt_unexp", gnt_o, 0);
                else chk("gnt", gnt_o, exp_q[0].gnt);
                for (int i = 0; i < NREQ; i++) if (gnt_o[i]) granted[i]++;
            end
            if (ext_re_o | ext_we_o) begin
                t_stb = cyc;
                n_stb++;
                inflight = 1'b1;
                chk("stb_pulse", prev_stb, 0);
                if (exp_q.size() > 0) begin
                    chk("strobe", {ext_we_o, ext_re_o}, exp_q[0].we ? 2'b10 : 2'b01);
                    chk("addr", ext_addr_o, exp_q[0].addr);
                    if (exp_q[0].we) chk("wd", ext_wd_o, exp_q[0].wd);
                end
            end else if (inflight && rsp_valid_o == '0 && exp_q.size() > 0) begin
                chk("addr_hold", ext_addr_o, exp_q[0].addr);
                if (exp_q[0].we) chk("wd_hold", ext_wd_o, exp_q[0].wd);
            end
            prev_stb = ext_re_o | ext_we_o;
            if (rsp_valid_o != '0) begin
                t_rsp = cyc;
                n_rsp++;
                inflight = 1'b0;
                if (exp_q.size() == 0) chk("rsp_unexp", rsp_valid_o, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("rsp_valid", rsp_valid_o, e.gnt);
                    chk("rsp_rdata", rsp_rdata_o, e.rdata);
                    chk("rsp_err", rsp_err_o, e.err);
                end
            end else begin
                chk("rsp_idle0", {rsp_err_o, rsp_rdata_o}, 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int r0;
        int n;
        // Reset state
        repeat (3) @(posedge clk);
        #2;
        chk("rst_gnt", gnt_o, 0);
        chk("rst_rsp", rsp_valid_o, 0);
        chk("rst_rd_err", {rsp_err_o, rsp_rdata_o}, 0);
        chk("rst_stb", {ext_we_o, ext_re_o}, 0);
        chk("rst_addr_wd", {ext_addr_o, ext_wd_o}, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #2;

        // Single read, ack in ISSUE: grant N, strobe N+1, response N+2
        ext_rd_i = 32'hA5A5_0001;
        ack_dly  = 0;
        set_req(0, 1'b0, 8'h10, 32'h0);
        push(0, 1'b0, 8'h10, 32'h0, 32'hA5A5_0001, 1'b0);
        want[0]++;
        wait_done("t1_done", 50);
        chk("t1_stb_lat", t_stb - t_gnt, 1);
        chk("t1_rsp_lat", t_rsp - t_gnt, 2);

        // Both requesting from reset: strict rotation 01,10,01,10
        do_reset();
        ack_dly  = 3;
        ext_rd_i = 32'h1234_5678;
        set_req(0, 1'b0, 8'h20, 32'h0);
        set_req(1, 1'b0, 8'h21, 32'h0);
        push(0, 1'b0, 8'h20, 32'h0, 32'h1234_5678, 1'b0);
        push(1, 1'b0, 8'h21, 32'h0, 32'h1234_5678, 1'b0);
        push(0, 1'b0, 8'h20, 32'h0, 32'h1234_5678, 1'b0);
        push(1, 1'b0, 8'h21, 32'h0, 32'h1234_5678, 1'b0);
        s0 = n_stb;
        want[0] += 2;
        want[1] += 2;
        wait_done("t2_done", 200);
        chk("t2_stb_cnt", n_stb - s0, 4);
        chk("t2_rsp_lat", t_rsp - t_gnt, 5);

        // Write from requester 1; readback data must not leak into the response
        ack_dly = 2;
        set_req(1, 1'b1, 8'h3C, 32'hDEAD_BEEF);
        push(1, 1'b1, 8'h3C, 32'hDEAD_BEEF, 32'h0, 1'b0);
        s0 = n_stb;
        want[1]++;
        wait_done("t3_done", 50);
        chk("t3_stb_cnt", n_stb - s0, 1);
        chk("t3_rsp_lat", t_rsp - t_gnt, 4);

        // Spurious ack while idle: no response, next access is normal
        r0   = n_rsp;
        spur = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        spur = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("spur_no_rsp", n_rsp - r0, 0);
        ack_dly  = 0;
        ext_rd_i = 32'h0000_5A5A;
        set_req(0, 1'b0, 8'h7F, 32'h0);
        push(0, 1'b0, 8'h7F, 32'h0, 32'h0000_5A5A, 1'b0);
        want[0]++;
        wait_done("spur_next_done", 50);
        chk("spur_next_lat", t_rsp - t_gnt, 2);

        // No ack: forced error completion, or an indefinite hold
        ack_en   = 1'b0;
        ext_rd_i = 32'hCAFE_0000;
        set_req(0, 1'b0, 8'h44, 32'h0);
`ifdef ABR_EXT_REG_ARB_TIMEOUT_EN
        push(0, 1'b0, 8'h44, 32'h0, 32'h0, 1'b1);
        want[0]++;
        wait_done("to_done", 50);
        chk("to_lat", t_rsp - t_stb, TO);
        ack_en  = 1'b1;
        ack_dly = TO - 1;
        push(0, 1'b0, 8'h44, 32'h0, 32'hCAFE_0000, 1'b0);
        want[0]++;
        wait_done("to_ack_done", 50);
        chk("to_ack_lat", t_rsp - t_stb, TO);
        // Start another unacked access and reset it while it is in WAIT
        ack_en = 1'b0;
        push(0, 1'b0, 8'h44, 32'h0, 32'h0, 1'b1);
        s0 = n_stb;
        want[0]++;
        n = 0;
        while (n_stb == s0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        chk("arst_stb_seen", n_stb - s0, 1);
        #2;
`else
        push(0, 1'b0, 8'h44, 32'h0, 32'h0, 1'b0);
        r0 = n_rsp;
        want[0]++;
        repeat (1000) @(posedge clk);
        #2;
        chk("hang_no_rsp", n_rsp - r0, 0);
`endif
        // Asynchronous reset in WAIT: outputs drop within the same cycle
        chk("wait_addr_held", ext_addr_o, 8'h44);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_stb", {ext_we_o, ext_re_o}, 0);
        chk("arst_addr_wd", {ext_addr_o, ext_wd_o}, 0);
        chk("arst_rsp", rsp_valid_o, 0);
        chk("arst_gnt", gnt_o, 0);
        exp_q.delete();
        ack_en  = 1'b1;
        ack_dly = 1;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        ext_rd_i = 32'h0BAD_F00D;
        set_req(1, 1'b0, 8'h55, 32'h0);
        push(1, 1'b0, 8'h55, 32'h0, 32'h0BAD_F00D, 1'b0);
        want[1]++;
        wait_done("post_rst_done", 50);
        chk("post_rst_lat", t_rsp - t_gnt, 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
